// File: rtl/pkt_rx_pkg.sv
// Purpose : shared types and constants for the receive-side packet sequencer.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package pkt_rx_pkg;

    localparam int          PID_W        = 4;
    localparam logic [15:0] CRC_POLY     = 16'h8005;
    localparam logic [15:0] CRC_INIT     = 16'hFFFF;
    // Remainder left in the register after a good payload and its complemented
    // CRC have both been shifted through.
    localparam logic [15:0] CRC_RESIDUAL = 16'h800D;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PID_CHK = 3'd1,
        ST_DATA    = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERR     = 3'd4
    } seq_state_e;

    // One byte of CRC16 update. Bits enter LSB first, as they arrive on the
    // line. The register keeps x^15 in bit 15.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                               input logic [7:0]  b);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[15] ^ b[i]) begin
                c = {c[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/rx_idle_timer.sv
// Purpose : counts idle cycles between received bytes and flags expiry.
// Latency : expired is combinational during the cycle that would bring the count to TIMEOUT_CYCLES.
// Backpressure: none; the counter only observes its inputs.
//
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   clr       : clear the count (activity seen); overrides en
//   en        : count this cycle
//   expired   : this idle cycle is the TIMEOUT_CYCLES-th in a row
module rx_idle_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int              CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Flag on the increment that would reach TIMEOUT_CYCLES. The caller can
    // then react in the same cycle and its registered error lands right after
    // the last idle cycle.
    assign expired = en && !clr && (count == LAST);

    // Wrap on expiry so that a following state, such as the error state
    // waiting for its own timeout, starts counting from zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= expired ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/pkt_rx_sequencer.sv
// Purpose : classifies a decoded byte stream into PID / DATA / CRC fields and reports packet status.
// Latency : all outputs registered; a payload byte is emitted 1 cycle after the byte that pushes it out of the 2-deep hold buffer.
// Backpressure: none; the upstream decoder strobes bytes freely, and bytes arriving in DONE/ERR are discarded.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   abort            synchronous flush back to IDLE; pid is kept
//   byte_valid/in    received byte strobe and value
//   eop              end-of-packet pulse
//   pid, pid_valid   latched PID nibble and its acceptance pulse
//   data_out/valid   payload byte and its strobe
//   data_count       payload bytes emitted in the current or last packet
//   crc_out          received CRC: [7:0] older byte, [15:8] newer byte
//   pkt_done/pkt_err clean-end and error pulses
//   crc_err          CRC failure pulse alongside pkt_done
//   busy             sequencer is not in IDLE
// Optional feature: define PKT_RX_SEQ_CRC_CHECK_EN to build the CRC16 checker.
// Without it crc_err is tied low.
module pkt_rx_sequencer
    import pkt_rx_pkg::*;
#(
    parameter  int MAX_DATA_BYTES = 64,
    parameter  int TIMEOUT_CYCLES = 255,
    localparam int LEN_W          = $clog2(MAX_DATA_BYTES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic             byte_valid,
    input  logic [7:0]       byte_in,
    input  logic             eop,
    output logic [PID_W-1:0] pid,
    output logic             pid_valid,
    output logic [7:0]       data_out,
    output logic             data_valid,
    output logic [LEN_W-1:0] data_count,
    output logic [15:0]      crc_out,
    output logic             pkt_done,
    output logic             pkt_err,
    output logic             crc_err,
    output logic             busy
);

    seq_state_e state, state_nxt;

    logic [7:0] pid_byte;       // first byte of the packet, checked in PID_CHK
    logic [7:0] h_old, h_new;   // hold buffer; the last two bytes are the CRC
    logic [1:0] fill;

    logic tmr_en, tmr_clr, tmr_expired;

    // ---------------------------------------------------------------- decode
    logic       pid_ok, buf_full, overflow, load, emit;
    logic [1:0] fill_after;
    logic [7:0] h_old_after, h_new_after;

    assign pid_ok   = (pid_byte[7:4] == ~pid_byte[3:0]);
    assign buf_full = (fill == 2'd2);
    // A byte that would push a payload byte out beyond the limit is refused.
    assign overflow = (state == ST_DATA) && byte_valid && buf_full &&
                      (data_count == LEN_W'(MAX_DATA_BYTES));
    // A byte that arrives while the PID is checked already belongs to the
    // payload, so it is taken in as well.
    assign load     = byte_valid && (((state == ST_PID_CHK) && pid_ok) ||
                                     ((state == ST_DATA) && !overflow));
    assign emit     = load && buf_full;

    // Buffer contents after this cycle's byte. eop is judged on these values.
    assign fill_after  = load ? (buf_full ? 2'd2 : fill + 2'd1) : fill;
    assign h_old_after = load ? h_new   : h_old;
    assign h_new_after = load ? byte_in : h_new;

`ifdef PKT_RX_SEQ_CRC_CHECK_EN
    logic [15:0] crc_acc, crc_base, crc_after;
    assign crc_base  = (state == ST_PID_CHK) ? CRC_INIT : crc_acc;
    assign crc_after = load ? crc16_byte(crc_base, byte_in) : crc_base;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            crc_acc <= CRC_INIT;
        end else if ((state == ST_PID_CHK) || (state == ST_DATA)) begin
            crc_acc <= crc_after;
        end
    end
`endif

    // -------------------------------------------------------------- idle timer
    assign tmr_en  = (state == ST_PID_CHK) || (state == ST_DATA) || (state == ST_ERR);
    assign tmr_clr = byte_valid || eop || abort;

    rx_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // ---------------------------------------------------------- state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------- next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (byte_valid) state_nxt = ST_PID_CHK;
            end
            ST_PID_CHK: begin
                // An eop here always finds fewer than two buffered bytes.
                if (!pid_ok || eop || tmr_expired) state_nxt = ST_ERR;
                else                               state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (overflow || tmr_expired) state_nxt = ST_ERR;
                else if (eop)                state_nxt = (fill_after == 2'd2) ? ST_DONE : ST_ERR;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                if (eop || tmr_expired) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (abort) state_nxt = ST_IDLE;
    end

    // ------------------------------------------- output values (registered below)
    logic [PID_W-1:0] pid_nxt;
    logic             pid_valid_nxt, data_valid_nxt, pkt_done_nxt, pkt_err_nxt;
    logic [7:0]       data_out_nxt;
    logic [LEN_W-1:0] data_count_nxt;
    logic [15:0]      crc_out_nxt;
`ifdef PKT_RX_SEQ_CRC_CHECK_EN
    logic             crc_err_nxt;
`endif

    always_comb begin
        pid_nxt        = pid;
        pid_valid_nxt  = 1'b0;
        data_out_nxt   = data_out;
        data_valid_nxt = 1'b0;
        data_count_nxt = data_count;
        crc_out_nxt    = crc_out;
        pkt_done_nxt   = 1'b0;
        pkt_err_nxt    = 1'b0;
`ifdef PKT_RX_SEQ_CRC_CHECK_EN
        crc_err_nxt    = 1'b0;
`endif
        case (state)
            ST_PID_CHK: begin
                if (pid_ok) begin
                    pid_nxt        = pid_byte[PID_W-1:0];
                    pid_valid_nxt  = 1'b1;
                    data_count_nxt = '0;
                    pkt_err_nxt    = eop || tmr_expired;
                end else begin
                    pkt_err_nxt    = 1'b1;
                end
            end
            ST_DATA: begin
                if (overflow) begin
                    pkt_err_nxt = 1'b1;
                end else begin
                    if (emit) begin
                        data_out_nxt   = h_old;
                        data_valid_nxt = 1'b1;
                        data_count_nxt = data_count + 1'b1;
                    end
                    if (tmr_expired) begin
                        pkt_err_nxt = 1'b1;
                    end else if (eop) begin
                        if (fill_after == 2'd2) begin
                            crc_out_nxt  = {h_new_after, h_old_after};
                            pkt_done_nxt = 1'b1;
`ifdef PKT_RX_SEQ_CRC_CHECK_EN
                            crc_err_nxt  = (crc_after != CRC_RESIDUAL);
`endif
                        end else begin
                            pkt_err_nxt = 1'b1;
                        end
                    end
                end
            end
            default: begin
            end
        endcase
        // abort clears everything except the last accepted PID.
        if (abort) begin
            pid_nxt        = pid;
            pid_valid_nxt  = 1'b0;
            data_out_nxt   = '0;
            data_valid_nxt = 1'b0;
            data_count_nxt = '0;
            crc_out_nxt    = '0;
            pkt_done_nxt   = 1'b0;
            pkt_err_nxt    = 1'b0;
`ifdef PKT_RX_SEQ_CRC_CHECK_EN
            crc_err_nxt    = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pid        <= '0;
            pid_valid  <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            data_count <= '0;
            crc_out    <= '0;
            pkt_done   <= 1'b0;
            pkt_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            pid        <= pid_nxt;
            pid_valid  <= pid_valid_nxt;
            data_out   <= data_out_nxt;
            data_valid <= data_valid_nxt;
            data_count <= data_count_nxt;
            crc_out    <= crc_out_nxt;
            pkt_done   <= pkt_done_nxt;
            pkt_err    <= pkt_err_nxt;
            busy       <= (state_nxt != ST_IDLE);
        end
    end

`ifdef PKT_RX_SEQ_CRC_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) crc_err <= 1'b0;
        else     crc_err <= crc_err_nxt;
    end
`else
    assign crc_err = 1'b0;
`endif

    // --------------------------------------------------------- datapath state
    always_ff @(posedge clk) begin
        if (rst) begin
            pid_byte <= '0;
        end else if ((state == ST_IDLE) && byte_valid && !abort) begin
            pid_byte <= byte_in;
        end
    end

    // The buffer is emptied in every IDLE cycle. Each packet therefore starts
    // with fill == 0 whichever way the previous one ended.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            fill  <= 2'd0;
            h_old <= '0;
            h_new <= '0;
        end else if (state == ST_IDLE) begin
            fill  <= 2'd0;
        end else if (load) begin
            h_old <= h_new;
            h_new <= byte_in;
            fill  <= fill_after;
        end
    end

endmodule

// File: tb/tb_pkt_rx_sequencer.sv
// Purpose : directed self-checking bench for pkt_rx_sequencer (MAX_DATA_BYTES=4, TIMEOUT_CYCLES=8).
// Latency : inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// Backpressure: n/a.
module tb_pkt_rx_sequencer;

    localparam int TB_MAX   = 4;
    localparam int TB_TMO   = 8;
    localparam int TB_LEN_W = $clog2(TB_MAX + 1);

    logic                clk;
    logic                rst;
    logic                abort;
    logic                byte_valid;
    logic [7:0]          byte_in;
    logic                eop;
    logic [3:0]          pid;
    logic                pid_valid;
    logic [7:0]          data_out;
    logic                data_valid;
    logic [TB_LEN_W-1:0] data_count;
    logic [15:0]         crc_out;
    logic                pkt_done;
    logic                pkt_err;
    logic                crc_err;
    logic                busy;

    int vectors    = 0;
    int miscompares = 0;
    int dv_cnt;

    pkt_rx_sequencer #(
        .MAX_DATA_BYTES (TB_MAX),
        .TIMEOUT_CYCLES (TB_TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .abort      (abort),
        .byte_valid (byte_valid),
        .byte_in    (byte_in),
        .eop        (eop),
        .pid        (pid),
        .pid_valid  (pid_valid),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_count (data_count),
        .crc_out    (crc_out),
        .pkt_done   (pkt_done),
        .pkt_err    (pkt_err),
        .crc_err    (crc_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic pulse_eop();
        eop = 1'b1;
        tick();
        eop = 1'b0;
    endtask

`ifdef PKT_RX_SEQ_CRC_CHECK_EN
    function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[15] ^ d[i]) ? ((r << 1) ^ 16'h8005) : (r << 1);
        end
        return r;
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction
`endif

    initial begin
        rst = 1'b1; abort = 1'b0; byte_valid = 1'b0; byte_in = '0; eop = 1'b0;
        repeat (3) tick();

        // reset state
        chk("rst_busy",      busy,       0);
        chk("rst_pid",       pid,        0);
        chk("rst_pid_valid", pid_valid,  0);
        chk("rst_dv",        data_valid, 0);
        chk("rst_count",     data_count, 0);
        chk("rst_crc",       crc_out,    0);
        chk("rst_done",      pkt_done,   0);
        chk("rst_err",       pkt_err,    0);
        chk("rst_crc_err",   crc_err,    0);
        rst = 1'b0;
        tick();

        // lone eop in IDLE is ignored
        pulse_eop();
        chk("idle_eop_busy", busy,    0);
        chk("idle_eop_err",  pkt_err, 0);

        // good packet A5 11 22 33 C1 C2 eop
        send(8'hA5);
        chk("t1_busy", busy, 1);
        chk("t1_pv_early", pid_valid, 0);
        tick();
        chk("t1_pid_valid", pid_valid, 1);
        chk("t1_pid",       pid,       4'h5);
        chk("t1_cnt0",      data_count, 0);
        send(8'h11); chk("t1_dv_b1", data_valid, 0);
        send(8'h22); chk("t1_dv_b2", data_valid, 0);
        send(8'h33); chk("t1_dv_b3", data_valid, 1); chk("t1_d0", data_out, 8'h11); chk("t1_c1", data_count, 1);
        send(8'hC1); chk("t1_dv_b4", data_valid, 1); chk("t1_d1", data_out, 8'h22); chk("t1_c2", data_count, 2);
        send(8'hC2); chk("t1_dv_b5", data_valid, 1); chk("t1_d2", data_out, 8'h33); chk("t1_c3", data_count, 3);
        pulse_eop();
        chk("t1_done",  pkt_done,   1);
        chk("t1_crc",   crc_out,    16'hC2C1);
        chk("t1_cnt",   data_count, 3);
        chk("t1_noerr", pkt_err,    0);
        chk("t1_dv_eop", data_valid, 0);
`ifndef PKT_RX_SEQ_CRC_CHECK_EN
        chk("t1_crc_err_tied", crc_err, 0);
`endif
        tick();
        chk("t1_idle",      busy,       0);
        chk("t1_done_off",  pkt_done,   0);
        chk("t1_cnt_hold",  data_count, 3);

        // bad PID 55: error, discard, eop returns to IDLE
        send(8'h55);
        tick();
        chk("t2_err",  pkt_err,   1);
        chk("t2_busy", busy,      1);
        chk("t2_pv",   pid_valid, 0);
        send(8'h12); chk("t2_err_once", pkt_err, 0);
        send(8'h34); chk("t2_dv", data_valid, 0);
        pulse_eop();
        chk("t2_idle", busy, 0);
        chk("t2_pid_kept", pid, 4'h5);

        // byte and eop in the same cycle: byte goes in first
        send(8'hA5); tick();
        send(8'h11);
        byte_valid = 1'b1; byte_in = 8'h22; eop = 1'b1;
        tick();
        byte_valid = 1'b0; eop = 1'b0;
        chk("t_same_done", pkt_done,   1);
        chk("t_same_crc",  crc_out,    16'h2211);
        chk("t_same_cnt",  data_count, 0);
        tick();

        // short packet: A5 11 eop
        dv_cnt = 0;
        send(8'hA5); tick();
        send(8'h11); dv_cnt += int'(data_valid);
        pulse_eop();
        dv_cnt += int'(data_valid);
        chk("t3_err",  pkt_err,  1);
        chk("t3_done", pkt_done, 0);
        chk("t3_cnt",  data_count, 0);
        for (int j = 1; j <= 7; j++) begin
            tick();
            dv_cnt += int'(data_valid);
        end
        chk("t3_err_wait", busy, 1);
        tick();
        chk("t3_err_tmo_idle", busy, 0);
        chk("t3_no_dv", dv_cnt, 0);

        // overflow with MAX_DATA_BYTES=4: A5 + 7 bytes
        send(8'hA5); tick();
        for (int i = 1; i <= 7; i++) begin
            send(8'(i));
            if (i >= 3 && i <= 6) begin
                chk("t4_dv",   data_valid, 1);
                chk("t4_data", data_out,   i - 2);
                chk("t4_cnt",  data_count, i - 2);
            end
        end
        chk("t4_ovf_err", pkt_err,    1);
        chk("t4_ovf_dv",  data_valid, 0);
        chk("t4_cnt_max", data_count, 4);
        pulse_eop();
        chk("t4_idle", busy, 0);

        // timeout with TIMEOUT_CYCLES=8: A5 11 then idle
        send(8'hA5); tick();
        send(8'h11);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("t5_tmo_err", pkt_err, (k == 8) ? 1 : 0);
        end
        chk("t5_busy_err", busy, 1);
        repeat (7) tick();
        chk("t5_err_wait", busy, 1);
        tick();
        chk("t5_err_exit", busy, 0);

        // mid-packet abort flushes the buffer and clears status; pid kept
        send(8'hA5); tick();
        send(8'h11); send(8'h22); send(8'h33);
        chk("t5a_pre_cnt", data_count, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5a_idle",  busy,       0);
        chk("t5a_cnt",   data_count, 0);
        chk("t5a_dout",  data_out,   0);
        chk("t5a_pid",   pid,        4'h5);
        send(8'hA5); tick();
        chk("t5a_pv", pid_valid, 1);
        send(8'h44); send(8'h55); send(8'h66);
        chk("t5a_dv",   data_valid, 1);
        chk("t5a_data", data_out,   8'h44);
        chk("t5a_cnt1", data_count, 1);
        pulse_eop();
        chk("t5a_done", pkt_done, 1);
        chk("t5a_crc",  crc_out,  16'h6655);
        tick();
        chk("t5a_end_idle", busy, 0);

`ifdef PKT_RX_SEQ_CRC_CHECK_EN
        begin
            logic [15:0] r;
            logic [7:0]  cb0, cb1;
            r   = ref_crc(ref_crc(16'hFFFF, 8'h00), 8'h01);
            cb0 = rev8(~r[15:8]);
            cb1 = rev8(~r[7:0]);
            // good DATA0 packet
            send(8'hC3); tick();
            send(8'h00); send(8'h01); send(cb0); send(cb1);
            pulse_eop();
            chk("t6_good_done",    pkt_done, 1);
            chk("t6_good_crc_err", crc_err,  0);
            tick();
            // same packet with one bit flipped
            send(8'hC3); tick();
            send(8'h00); send(8'h01); send(cb0 ^ 8'h01); send(cb1);
            pulse_eop();
            chk("t6_bad_done",    pkt_done, 1);
            chk("t6_bad_crc_err", crc_err,  1);
            tick();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach the end, observed stall expected completion");
        $fatal(1, "time limit");
    end

endmodule
